// File: rtl/elevator_pkg.sv
// Shared elevator definitions: direction encoding, default floor count and
// hall-clear helpers used by the scheduler and the request store.
package elevator_pkg;

  localparam int DEFAULT_FLOORS = 8;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_RSVD = 2'b11
  } dir_e;

  // The reserved encoding behaves like idle, so it releases both hall directions.
  function automatic logic clears_up(dir_e d);
    return d != DIR_DOWN;
  endfunction

  function automatic logic clears_down(dir_e d);
    return d != DIR_UP;
  endfunction

endpackage

// File: rtl/request_register_if.sv
// Button, serve and summary bundle between the request store and its users.
interface request_register_if
  import elevator_pkg::*;
#(
  parameter int FLOORS = DEFAULT_FLOORS
);
  localparam int FLOOR_W = $clog2(FLOORS);
  localparam int CNT_W   = $clog2(3 * FLOORS + 1);

  logic [FLOORS-1:0]  btn_num_in;
  logic [FLOORS-1:0]  btn_up_out;
  logic [FLOORS-1:0]  btn_down_out;
  logic [FLOOR_W-1:0] cur_floor;
  logic               serve_valid;
  dir_e               serve_dir;

  logic [FLOORS-1:0]  active_in_levels;
  logic [FLOORS-1:0]  active_out_up_levels;
  logic [FLOORS-1:0]  active_out_down_levels;
  logic               req_above;
  logic               req_below;
  logic               req_here;
  logic [CNT_W-1:0]   pending_count;

  modport master (
    output btn_num_in, btn_up_out, btn_down_out, cur_floor, serve_valid, serve_dir,
    input  active_in_levels, active_out_up_levels, active_out_down_levels,
           req_above, req_below, req_here, pending_count
  );

  modport slave (
    input  btn_num_in, btn_up_out, btn_down_out, cur_floor, serve_valid, serve_dir,
    output active_in_levels, active_out_up_levels, active_out_down_levels,
           req_above, req_below, req_here, pending_count
  );

endinterface

// File: rtl/btn_conditioner.sv
// One-bit button conditioner: 2-flop synchronizer, optional debounce filter
// (REQ_DEBOUNCE_EN) and rising-edge detector producing a one-cycle press pulse.
module btn_conditioner #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press_pulse
);

  logic sync1;
  logic sync2;
  logic cond;
  logic cond_q;

  // NOTE: non-blocking assignments so each flop samples its pre-edge input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef REQ_DEBOUNCE_EN
  localparam int RUN_W = $clog2(DEB_CYCLES + 1);

  logic [RUN_W-1:0] run;

  // Flip only after DEB_CYCLES consecutive samples disagree with the held value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond <= 1'b0;
      run  <= '0;
    end else if (sync2 == cond) begin
      run <= '0;
    end else if (run == RUN_W'(DEB_CYCLES - 1)) begin
      cond <= sync2;
      run  <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end
`else
  logic unused_deb_cycles;

  // Filter length has no effect without the debounce stage.
  assign unused_deb_cycles = ^DEB_CYCLES;
  assign cond = sync2;
`endif

  // Edge register starts at 0, so a button held through reset yields one press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cond_q <= 1'b0;
    else        cond_q <= cond;
  end

  assign press_pulse = cond & ~cond_q;

endmodule

// File: rtl/request_register.sv
// Sticky elevator request store: conditions cabin/hall buttons, clears served
// floors and publishes above/below/here summaries plus a pending count.
module request_register
  import elevator_pkg::*;
#(
  parameter int FLOORS     = DEFAULT_FLOORS,
  parameter int DEB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  request_register_if.slave  bus
);

  localparam int CNT_W = $clog2(3 * FLOORS + 1);

  // Top floor has no up button, ground floor has no down button.
  localparam logic [FLOORS-1:0] REACH_UP   = ~(FLOORS'(1) << (FLOORS - 1));
  localparam logic [FLOORS-1:0] REACH_DOWN = ~FLOORS'(1);

  logic [FLOORS-1:0] press_in, press_up, press_down;
  logic [FLOORS-1:0] lat_in, lat_up, lat_down;
  logic [FLOORS-1:0] clr_in, clr_up, clr_down;
  logic [FLOORS-1:0] any_req;
  logic              floor_ok;
  logic              above, below, here;

  for (genvar i = 0; i < FLOORS; i++) begin : g_btn
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_in (
      .clk(clk), .reset(reset), .raw(bus.btn_num_in[i]), .press_pulse(press_in[i])
    );
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_up (
      .clk(clk), .reset(reset), .raw(bus.btn_up_out[i]), .press_pulse(press_up[i])
    );
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_down (
      .clk(clk), .reset(reset), .raw(bus.btn_down_out[i]), .press_pulse(press_down[i])
    );
  end

  assign floor_ok = int'(bus.cur_floor) < FLOORS;

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    clr_in   = '0;
    clr_up   = '0;
    clr_down = '0;
    if (bus.serve_valid && floor_ok) begin
      clr_in[bus.cur_floor]   = 1'b1;
      clr_up[bus.cur_floor]   = clears_up(bus.serve_dir);
      clr_down[bus.cur_floor] = clears_down(bus.serve_dir);
    end
  end

  // Clear is applied after set so a press at the served floor is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_in   <= '0;
      lat_up   <= '0;
      lat_down <= '0;
    end else begin
      lat_in   <= (lat_in   | press_in)   & ~clr_in;
      lat_up   <= (lat_up   | press_up)   & ~clr_up   & REACH_UP;
      lat_down <= (lat_down | press_down) & ~clr_down & REACH_DOWN;
    end
  end

  assign any_req = lat_in | lat_up | lat_down;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (any_req[i]) begin
        if (i > int'(bus.cur_floor))  above = 1'b1;
        if (i < int'(bus.cur_floor))  below = 1'b1;
        if (i == int'(bus.cur_floor)) here  = 1'b1;
      end
    end
  end

  assign bus.active_in_levels       = lat_in;
  assign bus.active_out_up_levels   = lat_up;
  assign bus.active_out_down_levels = lat_down;
  assign bus.req_above              = above;
  assign bus.req_below              = below;
  assign bus.req_here               = here;
  assign bus.pending_count          = CNT_W'($countones({lat_in, lat_up, lat_down}));

endmodule

// File: tb/tb_request_register.sv
// Scoreboard bench for request_register: directed scenarios plus random traffic
// checked against a press/serve reference model of the request sets.
module tb_request_register;
  import elevator_pkg::*;

  localparam int FLOORS     = 8;
  localparam int DEB_CYCLES = 4;
  localparam int FLOOR_W    = $clog2(FLOORS);
  localparam int NB         = 3 * FLOORS;
`ifdef REQ_DEBOUNCE_EN
  localparam int LAT       = 3 + DEB_CYCLES;
  localparam int PRESS_LEN = DEB_CYCLES;
`else
  localparam int LAT       = 3;
  localparam int PRESS_LEN = 1;
`endif

  typedef logic [FLOORS-1:0] vec_t;
  typedef struct {
    vec_t in_l, up_l, down_l;
    logic above, below, here;
    int   count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  request_register_if #(.FLOORS(FLOORS)) bus ();
  request_register #(.FLOORS(FLOORS), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t Z = '0;

  // Reference state: request sets plus recent raw/conditioned button history.
  vec_t m_in, m_up, m_down;
  logic [NB-1:0] raw_d1, raw_d2, cond_d1, cond_d2, filt_m;
  int   run_m[NB];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = '0; m_up = '0; m_down = '0;
    raw_d1 = '0; raw_d2 = '0; cond_d1 = '0; cond_d2 = '0; filt_m = '0;
    for (int i = 0; i < NB; i++) run_m[i] = 0;
  endtask

  // Applies one clock edge using the inputs held during the cycle before it.
  task automatic model_edge();
    logic [NB-1:0] raw_now, press, cond_now;
    vec_t clr_in, clr_up, clr_down;
    int f;
    raw_now = {bus.btn_down_out, bus.btn_up_out, bus.btn_num_in};
    press   = cond_d1 & ~cond_d2;
`ifdef REQ_DEBOUNCE_EN
    for (int i = 0; i < NB; i++) begin
      if (raw_d2[i] != filt_m[i]) begin
        run_m[i]++;
        if (run_m[i] == DEB_CYCLES) begin
          filt_m[i] = raw_d2[i];
          run_m[i]  = 0;
        end
      end else run_m[i] = 0;
    end
    cond_now = filt_m;
`else
    cond_now = raw_d1;
`endif
    raw_d2 = raw_d1; raw_d1 = raw_now;
    cond_d2 = cond_d1; cond_d1 = cond_now;

    clr_in = '0; clr_up = '0; clr_down = '0;
    f = int'(bus.cur_floor);
    if (bus.serve_valid && f < FLOORS) begin
      clr_in[f]   = 1'b1;
      clr_up[f]   = bus.serve_dir inside {DIR_IDLE, DIR_UP, DIR_RSVD};
      clr_down[f] = bus.serve_dir inside {DIR_IDLE, DIR_DOWN, DIR_RSVD};
    end
    m_in   = (m_in   | press[0 +: FLOORS])      & ~clr_in;
    m_up   = (m_up   | press[FLOORS +: FLOORS]) & ~clr_up;
    m_down = (m_down | press[2*FLOORS +: FLOORS]) & ~clr_down;
    m_up[FLOORS-1] = 1'b0;
    m_down[0]      = 1'b0;
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    vec_t all;
    int   f;
    all = m_in | m_up | m_down;
    f   = int'(bus.cur_floor);
    e.in_l = m_in; e.up_l = m_up; e.down_l = m_down;
    e.above = 1'b0; e.below = 1'b0; e.here = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (all[i] && i > f)  e.above = 1'b1;
      if (all[i] && i < f)  e.below = 1'b1;
      if (all[i] && i == f) e.here  = 1'b1;
    end
    e.count = $countones(m_in) + $countones(m_up) + $countones(m_down);
    return e;
  endfunction

  task automatic cycle(vec_t in_b, vec_t up_b, vec_t dn_b,
                       logic [FLOOR_W-1:0] fl, logic sv, dir_e d);
    @(posedge clk); #1;
    model_edge();
    bus.btn_num_in = in_b; bus.btn_up_out = up_b; bus.btn_down_out = dn_b;
    bus.cur_floor = fl; bus.serve_valid = sv; bus.serve_dir = d;
    exp_q.push_back(model_expect());
  endtask

  task automatic idle(int n, logic [FLOOR_W-1:0] fl);
    repeat (n) cycle(Z, Z, Z, fl, 1'b0, DIR_IDLE);
  endtask

  // Start a press, then cross n more edges with the button held PRESS_LEN cycles.
  task automatic press(vec_t in_b, vec_t up_b, vec_t dn_b, logic [FLOOR_W-1:0] fl, int n);
    cycle(in_b, up_b, dn_b, fl, 1'b0, DIR_IDLE);
    for (int j = 1; j <= n; j++) begin
      if (j < PRESS_LEN) cycle(in_b, up_b, dn_b, fl, 1'b0, DIR_IDLE);
      else               cycle(Z, Z, Z, fl, 1'b0, DIR_IDLE);
    end
  endtask

  task automatic serve(logic [FLOOR_W-1:0] fl, dir_e d);
    cycle(Z, Z, Z, fl, 1'b1, d);
    cycle(Z, Z, Z, fl, 1'b0, DIR_IDLE);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_in",    bus.active_in_levels, 0);
    check("rst_up",    bus.active_out_up_levels, 0);
    check("rst_down",  bus.active_out_down_levels, 0);
    check("rst_above", bus.req_above, 0);
    check("rst_below", bus.req_below, 0);
    check("rst_here",  bus.req_here, 0);
    check("rst_count", bus.pending_count, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic vec_t rand_flip(vec_t v);
    for (int i = 0; i < FLOORS; i++)
      if ($urandom_range(5) == 0) v[i] = ~v[i];
    return v;
  endfunction

  // Monitor: the DUT presents its summaries every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_in",    bus.active_in_levels, e.in_l);
        check("sb_up",    bus.active_out_up_levels, e.up_l);
        check("sb_down",  bus.active_out_down_levels, e.down_l);
        check("sb_above", bus.req_above, e.above);
        check("sb_below", bus.req_below, e.below);
        check("sb_here",  bus.req_here, e.here);
        check("sb_count", bus.pending_count, e.count);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ri, ru, rd;
    bus.btn_num_in = '0; bus.btn_up_out = '0; bus.btn_down_out = '0;
    bus.cur_floor = '0; bus.serve_valid = 1'b0; bus.serve_dir = DIR_IDLE;
    model_reset();

    // Single hall-up press: invisible one edge early, then set with summaries.
    do_reset();
    press(Z, 8'h10, Z, 3'd2, LAT - 1);
    #2 check("tp1_early", bus.active_out_up_levels, 8'h00);
    idle(1, 3'd2);
    #2;
    check("tp1_up",    bus.active_out_up_levels, 8'h10);
    check("tp1_count", bus.pending_count, 1);
    check("tp1_above", bus.req_above, 1);
    check("tp1_below", bus.req_below, 0);

    // Serve floor 5 going up: only up[5] clears.
    do_reset();
    press(8'h02, 8'h20, 8'h80, 3'd0, LAT);
    serve(3'd5, DIR_UP);
    #2;
    check("tp2_up",    bus.active_out_up_levels, 8'h00);
    check("tp2_in",    bus.active_in_levels, 8'h02);
    check("tp2_down",  bus.active_out_down_levels, 8'h80);
    check("tp2_count", bus.pending_count, 2);

    // Directional clearing of hall buttons at floor 3.
    do_reset();
    press(Z, 8'h08, 8'h08, 3'd0, LAT);
    serve(3'd3, DIR_DOWN);
    #2;
    check("tp3_up_kept",  bus.active_out_up_levels, 8'h08);
    check("tp3_down_clr", bus.active_out_down_levels, 8'h00);
    serve(3'd3, DIR_IDLE);
    #2 check("tp3_idle_clr", bus.pending_count, 0);

    // Held cabin button at the served floor: clear wins, no re-set while held.
    do_reset();
    repeat (LAT + 3) cycle(8'h04, Z, Z, 3'd2, 1'b1, DIR_IDLE);
    #2 check("tp4_clear_wins", bus.active_in_levels, 8'h00);
    repeat (LAT + 1) cycle(8'h04, Z, Z, 3'd2, 1'b0, DIR_IDLE);
    #2 check("tp4_held_no_reset", bus.active_in_levels, 8'h00);
    idle(LAT + 1, 3'd2);
    press(8'h04, Z, Z, 3'd2, LAT);
    #2;
    check("tp4_repress", bus.active_in_levels, 8'h04);
    check("tp4_here",    bus.req_here, 1);

    // Unreachable hall buttons never latch.
    press(Z, 8'h80, 8'h01, 3'd2, LAT);
    #2;
    check("tp5_up",    bus.active_out_up_levels, 8'h00);
    check("tp5_down",  bus.active_out_down_levels, 8'h00);
    check("tp5_count", bus.pending_count, 1);

    // Reset mid-hold, button still held through release counts as one press.
    repeat (2) cycle(8'h01, Z, Z, 3'd0, 1'b0, DIR_IDLE);
    do_reset();
    repeat (LAT) cycle(8'h01, Z, Z, 3'd0, 1'b0, DIR_IDLE);
    #2 check("tp6_held_through_reset", bus.active_in_levels, 8'h01);
    idle(LAT + 1, 3'd0);

`ifdef REQ_DEBOUNCE_EN
    // Glitch shorter than the filter is dropped; a long press gets through.
    do_reset();
    repeat (2) cycle(8'h40, Z, Z, 3'd0, 1'b0, DIR_IDLE);
    idle(LAT + 2, 3'd0);
    #2 check("tp7_glitch", bus.active_in_levels, 8'h00);
    repeat (6) cycle(8'h40, Z, Z, 3'd0, 1'b0, DIR_IDLE);
    idle(LAT, 3'd0);
    #2 check("tp7_long", bus.active_in_levels, 8'h40);
`endif

    // Random traffic against the reference model, with occasional resets.
    do_reset();
    ri = '0; ru = '0; rd = '0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        ri = rand_flip(ri); ru = rand_flip(ru); rd = rand_flip(rd);
        cycle(ri, ru, rd, FLOOR_W'($urandom), ($urandom_range(3) == 0),
              dir_e'($urandom_range(3)));
      end
    end

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
